// File: rtl/dl_mem_writer.sv
// Buffers downloader byte writes in a small FIFO and replays them onto a req/ack memory port,
// holding the CPU off the bus until every queued byte has been acknowledged.
module dl_mem_writer #(
    parameter int unsigned FIFO_AW = 3,
    parameter int unsigned ADDR_W  = 25
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              dl_downloading_i,
    input  logic              dl_wr_i,
    input  logic [ADDR_W-1:0] dl_addr_i,
    input  logic [7:0]        dl_data_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_dout_o,
    input  logic              mem_ack_i,
    output logic              cpu_wait_o,
    output logic              done_o,
    output logic              overflow_o,
    output logic [ADDR_W-1:0] bytes_written_o
);
    localparam int unsigned Depth = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] CountFull = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic {StIdle, StReq} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   fifo_addr_q [Depth];
    logic [7:0]          fifo_data_q [Depth];
    logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]    count_q, count_d;
    logic                mem_req_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [7:0]          mem_dout_q;
    logic [ADDR_W-1:0]   bytes_q;
    logic                overflow_q;
    logic                dl_q;
    logic                cpu_wait_q;
    logic                done_q;

    logic full, push, pop, drop, sess_start;

    // Full is judged on the registered count, so a same-cycle pop cannot make room for a push.
    assign full       = (count_q == CountFull);
    assign push       = dl_wr_i & ~full;
    assign drop       = dl_wr_i & full;
    assign pop        = (state_q == StReq) & mem_ack_i;
    assign sess_start = dl_downloading_i & ~dl_q;

    assign cpu_wait_o = dl_downloading_i | (count_q != '0) | (state_q == StReq);

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= dl_addr_i;
            fifo_data_q[wr_ptr_q] <= dl_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_dout_q <= '0;
            bytes_q    <= '0;
            overflow_q <= 1'b0;
            dl_q       <= 1'b0;
            cpu_wait_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            dl_q       <= dl_downloading_i;
            cpu_wait_q <= cpu_wait_o;
            done_q     <= cpu_wait_q & ~cpu_wait_o;
            count_q    <= count_d;

            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

            // A drop in the first cycle of a new session still counts as an overflow.
            if (drop)            overflow_q <= 1'b1;
            else if (sess_start) overflow_q <= 1'b0;

            if (sess_start) bytes_q <= '0;
            else if (pop)   bytes_q <= bytes_q + 1'b1;

            unique case (state_q)
                StIdle: begin
                    if (count_q != '0) begin
                        mem_addr_q <= fifo_addr_q[rd_ptr_q];
                        mem_dout_q <= fifo_data_q[rd_ptr_q];
                        mem_req_q  <= 1'b1;
                        state_q    <= StReq;
                    end
                end
                StReq: begin
                    if (mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_req_o       = mem_req_q;
    assign mem_we_o        = mem_req_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_dout_o      = mem_dout_q;
    assign done_o          = done_q;
    assign overflow_o      = overflow_q;
    assign bytes_written_o = bytes_q;

endmodule

// File: tb/tb_dl_mem_writer.sv
// Self-checking bench for dl_mem_writer: directed scenarios plus randomized traffic against a
// queue-based model of the write buffer.
module tb_dl_mem_writer;
    localparam int unsigned FifoAw = 3;
    localparam int unsigned AddrW  = 25;
    localparam int unsigned Depth  = 8;

    logic             clk_i = 1'b0;
    logic             reset_i = 1'b1;
    logic             dl_downloading_i = 1'b0;
    logic             dl_wr_i = 1'b0;
    logic [AddrW-1:0] dl_addr_i = '0;
    logic [7:0]       dl_data_i = '0;
    logic             mem_req_o, mem_we_o;
    logic [AddrW-1:0] mem_addr_o;
    logic [7:0]       mem_dout_o;
    logic             mem_ack_i = 1'b0;
    logic             cpu_wait_o, done_o, overflow_o;
    logic [AddrW-1:0] bytes_written_o;

    dl_mem_writer #(.FIFO_AW(FifoAw), .ADDR_W(AddrW)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .dl_downloading_i(dl_downloading_i),
        .dl_wr_i(dl_wr_i), .dl_addr_i(dl_addr_i), .dl_data_i(dl_data_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_dout_o(mem_dout_o), .mem_ack_i(mem_ack_i), .cpu_wait_o(cpu_wait_o),
        .done_o(done_o), .overflow_o(overflow_o), .bytes_written_o(bytes_written_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int failed = 0;

    // Model state: queued {addr,data}, sticky flags, session byte count, expected done pulse.
    logic [AddrW+7:0] mq[$];
    logic [AddrW-1:0] got_addr[$];
    logic             m_ovf = 1'b0, m_prev_dl = 1'b0, m_prev_cw = 1'b0, m_done = 1'b0;
    logic [AddrW-1:0] m_bytes = '0;
    int               m_acc = 0;
    int cw_err = 0, done_err = 0, we_err = 0, stall_err = 0, stab_err = 0, order_err = 0;
    int idle_run = 0, age = 0, ack_mode = 0, ack_lat = 1;
    logic             req_seen = 1'b0;
    logic [AddrW+7:0] req_hold = '0;

    // Samples mid-cycle, advances the model across the next rising edge, then drives ack.
    task automatic tick();
        logic cw_now, full, pop, sess;
        logic [AddrW+7:0] head;
        @(negedge clk_i);
        cw_now = dl_downloading_i | (mq.size() != 0);
        if (cpu_wait_o !== cw_now) cw_err++;
        if (done_o !== m_done) done_err++;
        if (mem_we_o !== mem_req_o) we_err++;
        if (mq.size() != 0 && !mem_req_o) idle_run++;
        else idle_run = 0;
        if (idle_run > 1) stall_err++;
        if (req_seen && mem_req_o && {mem_addr_o, mem_dout_o} !== req_hold) stab_err++;
        req_seen = mem_req_o & ~mem_ack_i;
        req_hold = {mem_addr_o, mem_dout_o};
        full = (mq.size() == Depth);
        pop  = mem_req_o & mem_ack_i;
        sess = dl_downloading_i & ~m_prev_dl;
        if (pop) begin
            got_addr.push_back(mem_addr_o);
            if (mq.size() == 0) order_err++;
            else begin
                head = mq.pop_front();
                if ({mem_addr_o, mem_dout_o} !== head) order_err++;
            end
            m_bytes = m_bytes + 1'b1;
        end
        if (dl_wr_i && !full) begin
            mq.push_back({dl_addr_i, dl_data_i});
            m_acc++;
        end
        if (sess) begin
            m_bytes = '0;
            m_ovf   = 1'b0;
        end
        if (dl_wr_i && full) m_ovf = 1'b1;
        m_done    = m_prev_cw & ~cw_now;
        m_prev_cw = cw_now;
        m_prev_dl = dl_downloading_i;
        @(posedge clk_i);
        #1;
        if (mem_req_o) age++;
        else age = 0;
        case (ack_mode)
            1: mem_ack_i = mem_req_o && (age >= ack_lat);
            2: mem_ack_i = ($urandom_range(0, 2) == 0);
            default: ;
        endcase
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        dl_wr_i = 1'b0;
        mem_ack_i = 1'b0;
        ack_mode = 0;
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b0;
        mq.delete();
        m_ovf = 1'b0; m_bytes = '0; m_prev_dl = 1'b0; m_prev_cw = 1'b0; m_done = 1'b0;
        idle_run = 0; age = 0; req_seen = 1'b0;
    endtask

    task automatic push(input logic [AddrW-1:0] a, input logic [7:0] d);
        dl_wr_i = 1'b1;
        dl_addr_i = a;
        dl_data_i = d;
        tick();
        dl_wr_i = 1'b0;
    endtask

    task automatic new_session();
        dl_downloading_i = 1'b0;
        tick();
        dl_downloading_i = 1'b1;
        tick();
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget && (mq.size() != 0 || mem_req_o); c++) tick();
        tests++;
        if (mq.size() != 0 || mem_req_o) begin
            failed++;
            $display("FAIL drain_timeout: %0d entries still queued, want 0", mq.size());
        end
    endtask

    task automatic test_reset();
        logic [AddrW-1:0] got [8];
        logic [AddrW-1:0] want [8];
        dl_downloading_i = 1'b0;
        do_reset();
        got  = '{AddrW'(mem_req_o), AddrW'(mem_we_o), mem_addr_o, AddrW'(mem_dout_o),
                 AddrW'(done_o), AddrW'(overflow_o), bytes_written_o, AddrW'(cpu_wait_o)};
        want = '{default: '0};
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (got[i] !== want[i]) begin
                failed++;
                $display("FAIL reset_value[%0d]: got %0h want %0h", i, got[i], want[i]);
            end
        end
        dl_downloading_i = 1'b1;
        #1;
        tests++;
        if (cpu_wait_o !== 1'b1) begin
            failed++;
            $display("FAIL reset_cpu_wait_follows: got %0b want 1", cpu_wait_o);
        end
    endtask

    task automatic test_single_write();
        ack_mode = 0;
        mem_ack_i = 1'b1;
        tick();
        push(25'h0010995, 8'hA5);
        tests++;
        if (mem_req_o !== 1'b0) begin
            failed++; $display("FAIL single_req_early: got %0b want 0", mem_req_o);
        end
        tick();
        tests++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 25'h0010995 || mem_dout_o !== 8'hA5) begin
            failed++;
            $display("FAIL single_req: req %0b addr %0h data %0h want 1 10995 a5",
                     mem_req_o, mem_addr_o, mem_dout_o);
        end
        tick();
        tests++;
        if (mem_req_o !== 1'b0 || bytes_written_o !== 25'd1) begin
            failed++;
            $display("FAIL single_ack: req %0b bytes %0d want 0 1", mem_req_o, bytes_written_o);
        end
        tick();
        tests++;
        if (mem_req_o !== 1'b0) begin
            failed++; $display("FAIL single_one_cycle: req %0b want 0", mem_req_o);
        end
    endtask

    task automatic test_overflow_and_session();
        mem_ack_i = 1'b0;
        ack_mode = 0;
        new_session();
        for (int i = 0; i < 10; i++) begin
            push(AddrW'(i), 8'(i * 7 + 1));
            if (i == 7) begin
                tests++;
                if (overflow_o !== 1'b0) begin
                    failed++; $display("FAIL ovf_after_8: got %0b want 0", overflow_o);
                end
            end
            if (i == 8) begin
                tests++;
                if (overflow_o !== 1'b1) begin
                    failed++; $display("FAIL ovf_after_9: got %0b want 1", overflow_o);
                end
            end
        end
        got_addr.delete();
        ack_mode = 1;
        ack_lat = 1;
        drain(60);
        tests++;
        if (got_addr.size() != 8) begin
            failed++; $display("FAIL ovf_drain_count: got %0d want 8", got_addr.size());
        end
        for (int i = 0; i < 8 && i < got_addr.size(); i++) begin
            tests++;
            if (got_addr[i] !== AddrW'(i)) begin
                failed++; $display("FAIL ovf_drain_order[%0d]: got %0h want %0h", i, got_addr[i], i);
            end
        end
        tests++;
        if (bytes_written_o !== 25'd8 || overflow_o !== 1'b1) begin
            failed++;
            $display("FAIL ovf_end_state: bytes %0d ovf %0b want 8 1", bytes_written_o, overflow_o);
        end
        dl_downloading_i = 1'b0;
        tick();
        dl_downloading_i = 1'b1;
        tick();
        tests++;
        if (bytes_written_o !== 25'd0 || overflow_o !== 1'b0) begin
            failed++;
            $display("FAIL new_session_clear: bytes %0d ovf %0b want 0 0",
                     bytes_written_o, overflow_o);
        end
    endtask

    task automatic test_push_pop();
        ack_mode = 0;
        mem_ack_i = 1'b0;
        got_addr.delete();
        for (int i = 0; i < 3; i++) push(AddrW'(100 + i), 8'(i + 16));
        tests++;
        if (mem_req_o !== 1'b1) begin
            failed++; $display("FAIL pp_req_pending: got %0b want 1", mem_req_o);
        end
        dl_wr_i = 1'b1;
        dl_addr_i = AddrW'(103);
        dl_data_i = 8'h13;
        mem_ack_i = 1'b1;
        tick();
        dl_wr_i = 1'b0;
        mem_ack_i = 1'b0;
        // Occupancy must be back at 3, so exactly five more pushes fit before a drop.
        for (int i = 0; i < 5; i++) push(AddrW'(104 + i), 8'(i + 20));
        tests++;
        if (overflow_o !== 1'b0) begin
            failed++; $display("FAIL pp_count_kept: ovf %0b want 0 at 8 entries", overflow_o);
        end
        push(AddrW'(109), 8'h77);
        tests++;
        if (overflow_o !== 1'b1) begin
            failed++; $display("FAIL pp_full_at_8: ovf %0b want 1", overflow_o);
        end
        ack_mode = 1;
        ack_lat = 2;
        drain(80);
        tests++;
        if (got_addr.size() != 9) begin
            failed++; $display("FAIL pp_drain_count: got %0d want 9", got_addr.size());
        end
        for (int i = 0; i < 9 && i < got_addr.size(); i++) begin
            tests++;
            if (got_addr[i] !== AddrW'(100 + i)) begin
                failed++;
                $display("FAIL pp_order[%0d]: got %0d want %0d", i, got_addr[i], 100 + i);
            end
        end
    endtask

    task automatic test_completion();
        int pulses;
        bit fell;
        new_session();
        ack_mode = 1;
        ack_lat = 3;
        got_addr.delete();
        push(AddrW'(200), 8'h01);
        push(AddrW'(201), 8'h02);
        dl_downloading_i = 1'b0;
        fell = 0;
        for (int c = 0; c < 40 && !fell; c++) begin
            tick();
            if (cpu_wait_o === 1'b0) fell = 1;
        end
        tests++;
        if (!fell || got_addr.size() != 2 || bytes_written_o !== 25'd2) begin
            failed++;
            $display("FAIL cmp_wait_until_last_ack: fell %0b acks %0d bytes %0d want 1 2 2",
                     fell, got_addr.size(), bytes_written_o);
        end
        tests++;
        if (done_o !== 1'b0) begin
            failed++; $display("FAIL cmp_done_early: got %0b want 0", done_o);
        end
        tick();
        tests++;
        if (done_o !== 1'b1) begin
            failed++; $display("FAIL cmp_done_pulse: got %0b want 1", done_o);
        end
        pulses = 0;
        repeat (8) begin
            tick();
            if (done_o === 1'b1) pulses++;
        end
        tests++;
        if (pulses != 0) begin
            failed++; $display("FAIL cmp_single_pulse: extra pulses %0d want 0", pulses);
        end
    endtask

    task automatic test_reset_mid_request();
        int reqs;
        dl_downloading_i = 1'b1;
        ack_mode = 0;
        mem_ack_i = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) push(AddrW'(300 + i), 8'(i));
        tests++;
        if (mem_req_o !== 1'b1) begin
            failed++; $display("FAIL rst_mid_req_pending: got %0b want 1", mem_req_o);
        end
        #2 reset_i = 1'b1;
        #1;
        tests++;
        if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0) begin
            failed++;
            $display("FAIL rst_mid_async_drop: req %0b we %0b want 0 0", mem_req_o, mem_we_o);
        end
        dl_downloading_i = 1'b0;
        do_reset();
        mem_ack_i = 1'b1;
        reqs = 0;
        repeat (10) begin
            tick();
            if (mem_req_o === 1'b1) reqs++;
        end
        tests++;
        if (reqs != 0 || bytes_written_o !== 25'd0 || cpu_wait_o !== 1'b0) begin
            failed++;
            $display("FAIL rst_mid_flushed: reqs %0d bytes %0d wait %0b want 0 0 0",
                     reqs, bytes_written_o, cpu_wait_o);
        end
    endtask

    task automatic test_random();
        new_session();
        ack_mode = 2;
        got_addr.delete();
        m_acc = 0;
        for (int c = 0; c < 400; c++) begin
            dl_wr_i   = (c < 200) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 5) == 0);
            dl_addr_i = AddrW'($urandom);
            dl_data_i = 8'($urandom);
            tick();
        end
        dl_wr_i = 1'b0;
        dl_downloading_i = 1'b0;
        drain(300);
        tick();
        tests++;
        if (bytes_written_o !== m_bytes) begin
            failed++;
            $display("FAIL rnd_bytes: got %0d want %0d", bytes_written_o, m_bytes);
        end
        tests++;
        if (overflow_o !== m_ovf) begin
            failed++; $display("FAIL rnd_overflow: got %0b want %0b", overflow_o, m_ovf);
        end
        tests++;
        if (got_addr.size() != m_acc || cpu_wait_o !== 1'b0) begin
            failed++;
            $display("FAIL rnd_acks: got %0d acks wait %0b want %0d acks wait 0",
                     got_addr.size(), cpu_wait_o, m_acc);
        end
    endtask

    task automatic test_scoreboard();
        int errs [6];
        errs = '{cw_err, done_err, we_err, stall_err, stab_err, order_err};
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (errs[i] != 0) begin
                failed++;
                $display("FAIL cycle_check[%0d] (wait,done,we,stall,stable,order): %0d errors want 0",
                         i, errs[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_overflow_and_session();
        test_push_pop();
        test_completion();
        test_reset_mid_request();
        test_random();
        test_scoreboard();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d failed so far", failed);
        $fatal(1);
    end

endmodule
